// File: rtl/dac_serializer_pkg.sv
// Shared definitions for the pattern path (ramp stage and DAC serializer).
package pattern_pkg;

    localparam int SAMPLE_W  = 12;
    localparam int FRAME_W   = 16;
    localparam int PD_W      = 2;
    localparam int BIT_CNT_W = $clog2(FRAME_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // DAC frame: two don't-care zeros, power-down mode, then the sample.
    function automatic logic [FRAME_W-1:0] build_frame(input logic [PD_W-1:0]     pd,
                                                       input logic [SAMPLE_W-1:0] sample);
        return {{(FRAME_W - PD_W - SAMPLE_W){1'b0}}, pd, sample};
    endfunction

endpackage

// File: rtl/dac_serializer_if.sv
// Sample handshake between the ramp stage (master) and the DAC serializer (slave).
interface dac_serializer_if;
    import pattern_pkg::*;

    logic [SAMPLE_W-1:0] sample_in;
    logic [PD_W-1:0]     pd;
    logic                sample_valid;
    logic                sample_ready;

    modport master (
        output sample_in,
        output pd,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_in,
        input  pd,
        input  sample_valid,
        output sample_ready
    );

endinterface

// File: rtl/dac_serializer_sclk_gen.sv
// Serial clock divider: sclk toggles every CLK_DIV clk cycles while enabled,
// and parks low with the divider cleared while disabled.
module sclk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic sclk,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_cnt;
    logic             wrap;

    assign wrap      = en && (div_cnt == DIV_W'(CLK_DIV - 1));
    assign rise_tick = wrap && !sclk;
    assign fall_tick = wrap && sclk;

    // Half-period counter and the sclk register it toggles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
        end else if (!en) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
        end else if (wrap) begin
            div_cnt <= '0;
            sclk    <= ~sclk;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/dac_serializer.sv
// Serial DAC output stage: takes one sample per handshake and shifts a 16-bit
// frame MSB-first to a mode-0 SPI DAC, with a cs_n high gap between frames.
//
// state | meaning
// IDLE  | sample_ready high, waiting for sample_valid
// SHIFT | cs_n low, 16 bits clocked out on sclk
// GAP   | cs_n high for GAP_CYC cycles before the next accept
module dac_serializer
    import pattern_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int GAP_CYC = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    dac_serializer_if.slave        smp,
    output logic                   sclk,
    output logic                   sdata,
    output logic                   cs_n,
    output logic                   busy,
    output logic                   frame_done
);

    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    state_t                 state;
    logic [FRAME_W-1:0]     shreg;
    logic [FRAME_W-1:0]     shreg_nxt;
    logic [FRAME_W-1:0]     frame_in;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic [GAP_W-1:0]       gap_cnt;
    logic                   last_bit;
    logic                   sclk_en;
    logic                   rise_tick;
    logic                   fall_tick;

    assign frame_in         = build_frame(smp.pd, smp.sample_in);
    assign shreg_nxt        = shreg << 1;
    assign sclk_en          = (state == SHIFT);
    assign smp.sample_ready = (state == IDLE);
    assign busy             = (state != IDLE);

    sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (sclk_en),
        .sclk      (sclk),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    // Frame sequencing, shift register and registered DAC-side outputs.
    // last_bit is flagged on the final rising edge so the terminating falling
    // edge does not have to decode the bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            last_bit   <= 1'b0;
            sdata      <= 1'b0;
            cs_n       <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (smp.sample_valid) begin
                        shreg    <= frame_in;
                        sdata    <= frame_in[FRAME_W-1];
                        bit_cnt  <= BIT_CNT_W'(FRAME_W - 1);
                        last_bit <= 1'b0;
                        cs_n     <= 1'b0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (rise_tick && (bit_cnt == '0)) begin
                        last_bit <= 1'b1;
                    end
                    if (fall_tick) begin
                        if (last_bit) begin
                            last_bit   <= 1'b0;
                            cs_n       <= 1'b1;
                            sdata      <= 1'b0;
                            frame_done <= 1'b1;
                            gap_cnt    <= GAP_W'(GAP_CYC - 1);
                            state      <= GAP;
                        end else begin
                            shreg   <= shreg_nxt;
                            sdata   <= shreg_nxt[FRAME_W-1];
                            bit_cnt <= bit_cnt - BIT_CNT_W'(1);
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dac_serializer.sv
// Bench for dac_serializer: two instances (default timing and CLK_DIV=1/GAP_CYC=1),
// a transaction-level model of accept timing and frame contents, and a pin-level
// monitor that decodes frames the way the DAC would.
module tb_dac_serializer;
    import pattern_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #8 clk = ~clk;

    dac_serializer_if ifa ();
    dac_serializer_if ifb ();

    logic sclk_a, sdata_a, cs_n_a, busy_a, fd_a;
    logic sclk_b, sdata_b, cs_n_b, busy_b, fd_b;

    dac_serializer #(.CLK_DIV(2), .GAP_CYC(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .smp(ifa.slave),
        .sclk(sclk_a), .sdata(sdata_a), .cs_n(cs_n_a), .busy(busy_a), .frame_done(fd_a)
    );

    dac_serializer #(.CLK_DIV(1), .GAP_CYC(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .smp(ifb.slave),
        .sclk(sclk_b), .sdata(sdata_b), .cs_n(cs_n_b), .busy(busy_b), .frame_done(fd_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
        end
    endtask

    function automatic int cd(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    function automatic int gp(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    function automatic int period(input int d);
        return 32 * cd(d) + gp(d) + 1;
    endfunction

    // ---------------- reference model ----------------
    int          cyc = 0;
    bit          ever_acc [2];
    int          last_acc [2];
    int          acc_cnt  [2];
    logic [15:0] exp_a [$];
    logic [15:0] exp_b [$];

    function automatic bit mdl_ready(input int d, input int at);
        return !ever_acc[d] || ((at - last_acc[d]) >= period(d));
    endfunction

    function automatic int exp_size(input int d);
        return (d == 0) ? exp_a.size() : exp_b.size();
    endfunction

    function automatic logic [15:0] exp_pop(input int d);
        if (d == 0) return exp_a.pop_front();
        return exp_b.pop_front();
    endfunction

    // Accept rule: one sample per period; reset discards any frame still shifting.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                if (ever_acc[d] && ((cyc - last_acc[d]) < 32 * cd(d))) begin
                    if (d == 0) void'(exp_a.pop_back());
                    else        void'(exp_b.pop_back());
                    acc_cnt[d]--;
                end
                ever_acc[d] = 1'b0;
            end
        end else begin
            cyc++;
            if (ifa.sample_valid === 1'b1 && mdl_ready(0, cyc)) begin
                ever_acc[0] = 1'b1;
                last_acc[0] = cyc;
                acc_cnt[0]++;
                exp_a.push_back({2'b00, ifa.pd, ifa.sample_in});
            end
            if (ifb.sample_valid === 1'b1 && mdl_ready(1, cyc)) begin
                ever_acc[1] = 1'b1;
                last_acc[1] = cyc;
                acc_cnt[1]++;
                exp_b.push_back({2'b00, ifb.pd, ifb.sample_in});
            end
        end
    end

    // ---------------- pin monitor ----------------
    int          mcyc = 0;
    bit          in_fr     [2];
    bit          have_fall [2];
    logic        prev_cs   [2];
    logic        prev_sclk [2];
    logic        prev_sd   [2];
    logic [15:0] shv       [2];
    int          fs        [2];
    int          last_rise [2];
    int          rises     [2];
    int          terr      [2];
    int          fd_err    [2];
    int          idle_err  [2];
    int          rdy_err   [2];
    int          frames    [2];
    int          last_fall [2];
    int          fall_iv   [2];
    int          seen555   [2];

    task automatic mon_step(input int d, input logic sck, input logic sd, input logic cs,
                            input logic fd, input logic rdy, input logic bsy);
        string nm;
        logic [15:0] e;
        nm = (d == 0) ? "A" : "B";
        if (rdy !== mdl_ready(d, cyc + 1)) rdy_err[d]++;
        if (bsy !== !mdl_ready(d, cyc + 1)) rdy_err[d]++;
        if (fd !== (cs === 1'b1 && prev_cs[d] === 1'b0 && in_fr[d])) fd_err[d]++;
        if (cs === 1'b1) begin
            if (sck !== 1'b0 || sd !== 1'b0) idle_err[d]++;
            if (prev_cs[d] === 1'b0 && in_fr[d]) begin
                frames[d]++;
                if (shv[d] == 16'h0555) seen555[d]++;
                if (exp_size(d) == 0) begin
                    chk({nm, "_unexpected_frame"}, 32'(shv[d]), 32'hFFFF_FFFF);
                end else begin
                    e = exp_pop(d);
                    chk({nm, "_frame_data"}, 32'(shv[d]), 32'(e));
                end
                chk({nm, "_cs_low_cycles"}, mcyc - fs[d], 32 * cd(d));
                chk({nm, "_sclk_rises"}, rises[d], 16);
                chk({nm, "_bit_timing_errs"}, terr[d], 0);
                in_fr[d] = 1'b0;
            end
        end else if (cs === 1'b0) begin
            if (prev_cs[d] === 1'b1) begin
                in_fr[d]     = 1'b1;
                fs[d]        = mcyc;
                last_rise[d] = mcyc;
                rises[d]     = 0;
                terr[d]      = 0;
                shv[d]       = '0;
                if (have_fall[d]) fall_iv[d] = mcyc - last_fall[d];
                last_fall[d] = mcyc;
                have_fall[d] = 1'b1;
                if (sck !== 1'b0) terr[d]++;
            end else begin
                if (sd !== prev_sd[d] && !(prev_sclk[d] === 1'b1 && sck === 1'b0)) terr[d]++;
                if (sck === 1'b1 && prev_sclk[d] === 1'b0) begin
                    if ((mcyc - last_rise[d]) != ((rises[d] == 0) ? cd(d) : 2 * cd(d))) terr[d]++;
                    last_rise[d] = mcyc;
                    rises[d]++;
                    shv[d] = {shv[d][14:0], sd};
                end
            end
        end else begin
            idle_err[d]++;
        end
        prev_cs[d]   = cs;
        prev_sclk[d] = sck;
        prev_sd[d]   = sd;
    endtask

    // Sample DUT pins on the falling edge; reset abandons any partial frame.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                in_fr[d]     = 1'b0;
                have_fall[d] = 1'b0;
                prev_cs[d]   = 1'b1;
                prev_sclk[d] = 1'b0;
                prev_sd[d]   = 1'b0;
            end
        end else begin
            mcyc++;
            mon_step(0, sclk_a, sdata_a, cs_n_a, fd_a, ifa.sample_ready, busy_a);
            mon_step(1, sclk_b, sdata_b, cs_n_b, fd_b, ifb.sample_ready, busy_b);
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_in(input int d, input logic v, input logic [11:0] s, input logic [1:0] p);
        if (d == 0) begin
            ifa.sample_valid = v; ifa.sample_in = s; ifa.pd = p;
        end else begin
            ifb.sample_valid = v; ifb.sample_in = s; ifb.pd = p;
        end
    endtask

    function automatic logic dut_ready(input int d);
        return (d == 0) ? ifa.sample_ready : ifb.sample_ready;
    endfunction

    // Present a sample and hold it until taken; returns 2 ns after the accepting edge.
    task automatic send(input int d, input logic [11:0] s, input logic [1:0] p, input bit keep);
        bit ok;
        ok = 1'b0;
        set_in(d, 1'b1, s, p);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (dut_ready(d) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("send_timeout", 0, 1);
        @(posedge clk);
        #2;
        if (!keep) set_in(d, 1'b0, s, p);
    endtask

    task automatic wait_idle(input int d);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            #1;
            if (exp_size(d) == 0 && !in_fr[d] && dut_ready(d) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", 0, 1);
        @(posedge clk);
        #2;
    endtask

    initial begin
        bit ok;
        set_in(0, 1'b0, 12'h000, 2'b00);
        set_in(1, 1'b0, 12'h000, 2'b00);
        rst_n = 1'b0;
        #12;
        chk("rst_ready", 32'(ifa.sample_ready), 1);
        chk("rst_sclk", 32'(sclk_a), 0);
        chk("rst_sdata", 32'(sdata_a), 0);
        chk("rst_cs_n", 32'(cs_n_a), 1);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_frame_done", 32'(fd_a), 0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #2;

        // basic frame and power-down bits
        send(0, 12'hABC, 2'b00, 1'b0);
        wait_idle(0);
        send(0, 12'hFFF, 2'b11, 1'b0);
        wait_idle(0);

        // back-to-back with sample_valid held high
        send(0, 12'h000, 2'b00, 1'b1);
        send(0, 12'h001, 2'b00, 1'b1);
        @(negedge clk);
        #1 chk("A_accept_period_1", fall_iv[0], 67);
        @(posedge clk);
        #2;
        send(0, 12'h002, 2'b00, 1'b0);
        @(negedge clk);
        #1 chk("A_accept_period_2", fall_iv[0], 67);
        wait_idle(0);

        // sample_valid while busy is dropped; input changes don't disturb the frame
        send(0, 12'h2A7, 2'b01, 1'b0);
        repeat (20) @(posedge clk);
        #2 set_in(0, 1'b1, 12'h555, 2'b00);
        @(posedge clk);
        #2 set_in(0, 1'b0, 12'h555, 2'b00);
        repeat (10) @(posedge clk);
        #2 set_in(0, 1'b0, 12'h0F0, 2'b10);
        wait_idle(0);
        chk("A_no_555_frame", seen555[0], 0);

        // reset after the 7th sclk rising edge
        send(0, 12'h3C5, 2'b10, 1'b0);
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            #1;
            if (in_fr[0] && rises[0] >= 7) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("wait_7th_rise_timeout", 0, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_cs_n", 32'(cs_n_a), 1);
        chk("midrst_sclk", 32'(sclk_a), 0);
        chk("midrst_sdata", 32'(sdata_a), 0);
        chk("midrst_ready", 32'(ifa.sample_ready), 1);
        repeat (2) @(negedge clk);
        #4 rst_n = 1'b1;
        #1 chk("postrst_ready", 32'(ifa.sample_ready), 1);
        send(0, 12'h123, 2'b00, 1'b0);
        @(negedge clk);
        #1 chk("postrst_first_edge_accept", 32'(cs_n_a), 0);
        wait_idle(0);

        // fastest timing variant
        send(1, 12'hABC, 2'b01, 1'b0);
        wait_idle(1);
        send(1, 12'h7E1, 2'b00, 1'b1);
        send(1, 12'h7E2, 2'b11, 1'b0);
        @(negedge clk);
        #1 chk("B_accept_period", fall_iv[1], 34);
        wait_idle(1);

        // random traffic on both instances, with stray valid pulses while busy
        for (int i = 0; i < 14; i++) begin
            int d;
            d = $urandom_range(0, 1);
            send(d, 12'($urandom), 2'($urandom), 1'b0);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 20)) @(posedge clk);
                #2 set_in(d, 1'b1, 12'($urandom), 2'($urandom));
                @(posedge clk);
                #2 set_in(d, 1'b0, 12'h000, 2'b00);
            end
            if ($urandom_range(0, 2) == 0) wait_idle(d);
            repeat ($urandom_range(0, 4)) @(posedge clk);
            #2;
        end
        wait_idle(0);
        wait_idle(1);

        for (int d = 0; d < 2; d++) begin
            string nm;
            nm = (d == 0) ? "A" : "B";
            chk({nm, "_ready_busy_timing_errs"}, rdy_err[d], 0);
            chk({nm, "_frame_done_errs"}, fd_err[d], 0);
            chk({nm, "_idle_level_errs"}, idle_err[d], 0);
            chk({nm, "_frame_count"}, frames[d], acc_cnt[d]);
            chk({nm, "_pending_frames"}, exp_size(d), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
